// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), sync polarity encodings
// and the line/frame total helper used by vga_timing_gen.
package vga_timing_pkg;

  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam bit SYNC_ACT_LOW  = 1'b0;
  localparam bit SYNC_ACT_HIGH = 1'b1;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } vga_sync_t;

  function automatic int vga_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/clk_enable_div.sv
// Clock-enable divider: counts 0..CLK_DIV-1 while enabled and raises tick
// for the single cycle sitting on the last count.
module clk_enable_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("clk_enable_div: CLK_DIV must be >= 1");
  end

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    div_cnt <= '0;
    else if (enable) div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CW'(1);
  end

  // Gated by reset so CLK_DIV=1 cannot strobe while the chain is held in reset.
  assign tick = reset_n & enable & (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, x/y counters, registered sync/active.
// Optional pix_clk square-wave output when VGA_TIMING_PIX_CLK_OUT_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = SYNC_ACT_LOW,
  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  output logic          pix_en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_PIX_CLK_OUT_EN
  ,
  output logic          pix_clk
`endif
);

  if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
    $error("vga_timing_gen: every timing parameter must be >= 1");
  end

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] X_ACTIVE = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_ACTIVE = YW'(V_ACTIVE);
  localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  vga_sync_t     sync_nxt;
  logic          h_in, v_in;

  clk_enable_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (pix_en)
  );

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (pix_en) begin
      if (x == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y == Y_LAST) ? '0 : y + YW'(1);
      end else begin
        x_nxt = x + XW'(1);
      end
    end
  end

  // Decoding the next position keeps the registered syncs aligned with x/y.
  always_comb begin
    h_in            = (x_nxt >= HS_BEG) && (x_nxt < HS_END);
    v_in            = (y_nxt >= VS_BEG) && (y_nxt < VS_END);
    sync_nxt.hsync  = SYNC_POL ? h_in : ~h_in;
    sync_nxt.vsync  = SYNC_POL ? v_in : ~v_in;
    sync_nxt.active = (x_nxt < X_ACTIVE) && (y_nxt < Y_ACTIVE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x      <= '0;
      y      <= '0;
      hsync  <= ~SYNC_POL;
      vsync  <= ~SYNC_POL;
      active <= 1'b1;
    end else begin
      x      <= x_nxt;
      y      <= y_nxt;
      hsync  <= sync_nxt.hsync;
      vsync  <= sync_nxt.vsync;
      active <= sync_nxt.active;
    end
  end

  assign line_start  = pix_en & (x == '0);
  assign frame_start = line_start & (y == '0);

`ifdef VGA_TIMING_PIX_CLK_OUT_EN
  if ((CLK_DIV % 2) != 0) begin : g_bad_pix_clk
    $error("vga_timing_gen: pix_clk output needs an even CLK_DIV");
  end

  // A half-rate divider ticks at counts CLK_DIV/2-1 and CLK_DIV-1 of the main one.
  logic half_tick;

  clk_enable_div #(.CLK_DIV(CLK_DIV / 2)) u_half_div (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (half_tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       pix_clk <= 1'b0;
    else if (half_tick) pix_clk <= ~pix_clk;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: closed-form raster model checked every cycle on four
// configurations, plus directed pause / mid-frame reset scenarios.
module tb_vga_timing_gen;

  typedef struct packed {
    int d, ha, hf, hs, hb, va, vf, vs, vb, pol;
  } cfg_t;

  typedef struct packed {
    logic pe, ls, fs, hs, vs, act, pc;
    int   x, y;
  } exp_t;

`ifdef VGA_TIMING_PIX_CLK_OUT_EN
  localparam int C_DIV = 2;
`else
  localparam int C_DIV = 1;
`endif

  localparam cfg_t CA = '{d:2, ha:4, hf:1, hs:2, hb:1, va:2, vf:1, vs:1, vb:1, pol:0};
  localparam cfg_t CB = '{d:4, ha:16, hf:2, hs:3, hb:2, va:4, vf:1, vs:2, vb:1, pol:1};
  localparam cfg_t CC = '{d:C_DIV, ha:4, hf:1, hs:2, hb:1, va:2, vf:1, vs:1, vb:1, pol:0};
  localparam cfg_t CD = '{d:4, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, pol:0};

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic en_a    = 1'b1;
  logic en_b    = 1'b1;

  always #5 clock = ~clock;

  logic a_pe, a_ls, a_fs, a_hs, a_vs, a_act;
  logic b_pe, b_ls, b_fs, b_hs, b_vs, b_act;
  logic c_pe, c_ls, c_fs, c_hs, c_vs, c_act;
  logic d_pe, d_ls, d_fs, d_hs, d_vs, d_act;
  logic [2:0] a_x, a_y, b_y, c_x, c_y;
  logic [4:0] b_x;
  logic [9:0] d_x, d_y;
`ifdef VGA_TIMING_PIX_CLK_OUT_EN
  logic a_pc, b_pc, c_pc, d_pc;
`endif

  vga_timing_gen #(.CLK_DIV(CA.d), .H_ACTIVE(CA.ha), .H_FP(CA.hf), .H_SYNC(CA.hs), .H_BP(CA.hb),
    .V_ACTIVE(CA.va), .V_FP(CA.vf), .V_SYNC(CA.vs), .V_BP(CA.vb), .SYNC_POL(1'b0)) u_a (
    .clock(clock), .reset_n(reset_n), .enable(en_a), .pix_en(a_pe), .x(a_x), .y(a_y),
    .hsync(a_hs), .vsync(a_vs), .active(a_act), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_PIX_CLK_OUT_EN
    , .pix_clk(a_pc)
`endif
  );

  vga_timing_gen #(.CLK_DIV(CB.d), .H_ACTIVE(CB.ha), .H_FP(CB.hf), .H_SYNC(CB.hs), .H_BP(CB.hb),
    .V_ACTIVE(CB.va), .V_FP(CB.vf), .V_SYNC(CB.vs), .V_BP(CB.vb), .SYNC_POL(1'b1)) u_b (
    .clock(clock), .reset_n(reset_n), .enable(en_b), .pix_en(b_pe), .x(b_x), .y(b_y),
    .hsync(b_hs), .vsync(b_vs), .active(b_act), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TIMING_PIX_CLK_OUT_EN
    , .pix_clk(b_pc)
`endif
  );

  vga_timing_gen #(.CLK_DIV(CC.d), .H_ACTIVE(CC.ha), .H_FP(CC.hf), .H_SYNC(CC.hs), .H_BP(CC.hb),
    .V_ACTIVE(CC.va), .V_FP(CC.vf), .V_SYNC(CC.vs), .V_BP(CC.vb), .SYNC_POL(1'b0)) u_c (
    .clock(clock), .reset_n(reset_n), .enable(en_a), .pix_en(c_pe), .x(c_x), .y(c_y),
    .hsync(c_hs), .vsync(c_vs), .active(c_act), .line_start(c_ls), .frame_start(c_fs)
`ifdef VGA_TIMING_PIX_CLK_OUT_EN
    , .pix_clk(c_pc)
`endif
  );

  vga_timing_gen u_d (
    .clock(clock), .reset_n(reset_n), .enable(en_a), .pix_en(d_pe), .x(d_x), .y(d_y),
    .hsync(d_hs), .vsync(d_vs), .active(d_act), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_PIX_CLK_OUT_EN
    , .pix_clk(d_pc)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Position follows from the number of enabled clocks since reset.
  function automatic exp_t model(input cfg_t c, input longint n, input logic en, input logic rst);
    exp_t   e;
    longint p;
    int     d, ht, vt;
    logic   ih, iv;
    ht    = c.ha + c.hf + c.hs + c.hb;
    vt    = c.va + c.vf + c.vs + c.vb;
    p     = n / c.d;
    d     = int'(n % c.d);
    e.x   = int'(p % ht);
    e.y   = int'((p / ht) % vt);
    e.pe  = rst && en && (d == c.d - 1);
    e.ls  = e.pe && (e.x == 0);
    e.fs  = e.ls && (e.y == 0);
    ih    = (e.x >= c.ha + c.hf) && (e.x < c.ha + c.hf + c.hs);
    iv    = (e.y >= c.va + c.vf) && (e.y < c.va + c.vf + c.vs);
    e.hs  = (c.pol != 0) ? ih : !ih;
    e.vs  = (c.pol != 0) ? iv : !iv;
    e.act = (e.x < c.ha) && (e.y < c.va);
    e.pc  = (d >= c.d / 2);
    return e;
  endfunction

  task automatic chk(input string tag, input exp_t e, input logic pe, input logic ls,
                     input logic fs, input logic hs, input logic vs, input logic act,
                     input int x, input int y);
    cmp({tag, ".x"}, x, e.x);
    cmp({tag, ".y"}, y, e.y);
    cmp({tag, ".pix_en"}, int'(pe), int'(e.pe));
    cmp({tag, ".line_start"}, int'(ls), int'(e.ls));
    cmp({tag, ".frame_start"}, int'(fs), int'(e.fs));
    cmp({tag, ".hsync"}, int'(hs), int'(e.hs));
    cmp({tag, ".vsync"}, int'(vs), int'(e.vs));
    cmp({tag, ".active"}, int'(act), int'(e.act));
  endtask

  longint n_a, n_b;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n_a <= 0;
      n_b <= 0;
    end else begin
      if (en_a) n_a <= n_a + 1;
      if (en_b) n_b <= n_b + 1;
    end
  end

  always @(negedge clock) begin
    exp_t ea, eb, ec, ed;
    ea = model(CA, n_a, en_a, reset_n);
    eb = model(CB, n_b, en_b, reset_n);
    ec = model(CC, n_a, en_a, reset_n);
    ed = model(CD, n_a, en_a, reset_n);
    chk("A", ea, a_pe, a_ls, a_fs, a_hs, a_vs, a_act, int'(a_x), int'(a_y));
    chk("B", eb, b_pe, b_ls, b_fs, b_hs, b_vs, b_act, int'(b_x), int'(b_y));
    chk("C", ec, c_pe, c_ls, c_fs, c_hs, c_vs, c_act, int'(c_x), int'(c_y));
    chk("D", ed, d_pe, d_ls, d_fs, d_hs, d_vs, d_act, int'(d_x), int'(d_y));
`ifdef VGA_TIMING_PIX_CLK_OUT_EN
    cmp("A.pix_clk", int'(a_pc), int'(ea.pc));
    cmp("B.pix_clk", int'(b_pc), int'(eb.pc));
    cmp("C.pix_clk", int'(c_pc), int'(ec.pc));
    cmp("D.pix_clk", int'(d_pc), int'(ed.pc));
`endif
  end

  // Hand-derived expectations that pin the model.
  int   a_last  = -1;
  int   c_prev  = -1;
  logic d_hs_q  = 1'b1;
  int   d_falls = 0;
  int   d_rises = 0;
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      a_last = -1;
      c_prev = -1;
      d_hs_q = 1'b1;
    end else begin
      cmp("A.hsync_tbl", int'(a_hs), (a_x == 3'd5 || a_x == 3'd6) ? 0 : 1);
      cmp("A.vsync_tbl", int'(a_vs), (a_y == 3'd3) ? 0 : 1);
      if (a_fs) begin
        if (a_last >= 0) cmp("A.frame_period", cyc - a_last, 80);
        a_last = cyc;
      end
`ifndef VGA_TIMING_PIX_CLK_OUT_EN
      cmp("C.pix_en_const", int'(c_pe), 1);
      if (c_prev >= 0) cmp("C.x_step", int'(c_x), (c_prev + 1) % 8);
      c_prev = int'(c_x);
`endif
      if (d_hs_q && !d_hs) begin
        cmp("D.hsync_fall_x", int'(d_x), 656);
        d_falls++;
      end
      if (!d_hs_q && d_hs) begin
        cmp("D.hsync_rise_x", int'(d_x), 752);
        d_rises++;
      end
      d_hs_q = d_hs;
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic first_pe_b(input string nm);
    int k;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clock);
      if (b_pe) k = i;
    end
    cmp({nm, ".clocks"}, k, 4);
    cmp({nm, ".line_start"}, int'(b_ls), 1);
    cmp({nm, ".frame_start"}, int'(b_fs), 1);
  endtask

  initial begin
    int found;
    reset_n = 1'b0;
    en_a    = 1'b1;
    en_b    = 1'b1;
    step(3);
    reset_n = 1'b1;
    first_pe_b("B.first_pe");

    // Pause B mid-line at x=12.
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      step(1);
      if (b_x == 5'd12) found = 1;
    end
    cmp("B.reach_x12", found, 1);
    en_b = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      cmp("B.pause_x", int'(b_x), 12);
      cmp("B.pause_pe", int'(b_pe), 0);
    end
    en_b  = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clock);
      if (b_pe) found = 1;
    end
    cmp("B.resume_pe", found, 1);
    cmp("B.resume_x_before", int'(b_x), 12);
    step(1);
    cmp("B.resume_x_after", int'(b_x), 13);

    // Reset while inside both sync pulses.
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      step(1);
      if (b_y == 3'd5 && b_x == 5'd19) found = 1;
    end
    cmp("B.reach_sync", found, 1);
    cmp("B.pre_hsync", int'(b_hs), 1);
    cmp("B.pre_vsync", int'(b_vs), 1);
    reset_n = 1'b0;
    #1;
    cmp("B.rst_x", int'(b_x), 0);
    cmp("B.rst_y", int'(b_y), 0);
    cmp("B.rst_hsync", int'(b_hs), 0);
    cmp("B.rst_vsync", int'(b_vs), 0);
    cmp("B.rst_active", int'(b_act), 1);
    cmp("B.rst_pix_en", int'(b_pe), 0);
    cmp("A.rst_hsync", int'(a_hs), 1);
    step(2);
    reset_n = 1'b1;
    first_pe_b("B.post_rst_pe");

    // Long enough for the default config to run its first hsync pulse.
    step(3300);
    cmp("D.hsync_falls", d_falls, 1);
    cmp("D.hsync_rises", d_rises, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
